// File: rtl/rep3_chip_tx.sv
// Repetition-code chip transmitter: serialises a DATA_W-bit word LSB first,
// each bit sent as REP identical chips of CHIP_DIV clocks, then idles GAP cycles.
module rep3_chip_tx #(
  parameter int DATA_W   = 8,
  parameter int REP      = 3,
  parameter int CHIP_DIV = 1,
  parameter int GAP      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_sof,
  output logic              tx_eof
);
  localparam int BW = (DATA_W   > 1) ? $clog2(DATA_W)   : 1;
  localparam int CW = (REP      > 1) ? $clog2(REP)      : 1;
  localparam int DW = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
  localparam int GW = (GAP      > 1) ? $clog2(GAP)      : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [CW-1:0] CHIP_LAST = CW'(REP - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CHIP_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam bit            ONE_CYC   = (DATA_W * REP * CHIP_DIV == 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  typedef struct packed {
    logic rdy;
    logic chip;
    logic vld;
    logic sof;
    logic eof;
  } out_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     chip_q, chip_d;
  logic [DW-1:0]     div_q, div_d;
  logic [GW-1:0]     gap_q, gap_d;
  out_t              o_q, o_d;
  logic              last;

  assign last = (div_q == DIV_LAST) && (chip_q == CHIP_LAST) && (bit_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    chip_d  = chip_q;
    div_d   = div_q;
    gap_d   = gap_q;
    o_d     = '0;
    case (state_q)
      S_IDLE: begin
        o_d.rdy = 1'b1;
        // Acceptance keys off the registered ready so the first post-reset cycle is ignored.
        if (o_q.rdy && in_valid) begin
          state_d  = S_SEND;
          sh_d     = in_data;
          bit_d    = '0;
          chip_d   = '0;
          div_d    = '0;
          o_d.rdy  = 1'b0;
          o_d.vld  = 1'b1;
          o_d.sof  = 1'b1;
          o_d.eof  = ONE_CYC;
          o_d.chip = in_data[0];
        end
      end
      S_SEND: begin
        if (last) begin
          sh_d   = '0;
          bit_d  = '0;
          chip_d = '0;
          div_d  = '0;
          if (GAP > 0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
            o_d.rdy = 1'b1;
          end
        end else begin
          o_d.vld  = 1'b1;
          o_d.chip = o_q.chip;
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (chip_q == CHIP_LAST) begin
              chip_d   = '0;
              bit_d    = bit_q + 1'b1;
              sh_d     = sh_q >> 1;
              o_d.chip = sh_d[0];
            end else begin
              chip_d = chip_q + 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
          // Flag the final cycle one edge ahead so tx_eof stays registered.
          o_d.eof = (div_d == DIV_LAST) && (chip_d == CHIP_LAST) && (bit_d == BIT_LAST);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
          o_d.rdy = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      chip_q  <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      chip_q  <= chip_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      o_q     <= o_d;
    end
  end

  assign in_ready = o_q.rdy;
  assign tx_bit   = o_q.chip;
  assign tx_valid = o_q.vld;
  assign tx_sof   = o_q.sof;
  assign tx_eof   = o_q.eof;
endmodule

// File: doc/rep3_chip_tx.md
Name: rep3_chip_tx

Overview:
- Serial transmitter for the rate-1/REP repetition code; the team's 3-input majority voter is the receive end.
- Accepts a DATA_W-bit word over a valid/ready handshake and serialises it LSB first.
- Sends each data bit as REP consecutive identical chips, each chip held CHIP_DIV clocks.
- Marks frame start and end, then inserts a programmable idle gap before the next word.

Parameters:
- DATA_W, 8, payload bits per frame (>=1).
- REP, 3, chips per data bit (odd, >=3; 3 matches the voter).
- CHIP_DIV, 1, clock cycles per chip (>=1).
- GAP, 1, idle cycles after a frame before in_ready reasserts (>=0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid.
- in_data  input  DATA_W  word to transmit.
- in_ready  output  1  block can accept a word this cycle.
- tx_bit  output  1  current chip value.
- tx_valid  output  1  tx_bit carries a chip.
- tx_sof  output  1  first cycle of the first chip of a frame.
- tx_eof  output  1  last cycle of the last chip of a frame.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- All outputs are registered.
- Reset (rst_n=0, immediate): state IDLE; in_ready=0, tx_bit=0, tx_valid=0, tx_sof=0, tx_eof=0; shift register, chip/bit/div/gap counters all 0.
- in_ready rises on the first clk edge after rst_n deasserts.
- States: IDLE, SEND, GAP.
- IDLE: in_ready=1, tx_valid=0, tx_bit=0.
  - On an edge with in_valid=1: latch in_data, go to SEND, drop in_ready.
  - tx_valid=1 and tx_sof=1 are registered at that same edge, so the first chip appears in the next cycle (1-cycle latency).
  - tx_bit=in_data[0] at that point.
- SEND:
  - Each chip lasts CHIP_DIV cycles; each bit lasts REP chips.
  - After REP chips, shift right and present the next bit.
  - Frame length = DATA_W*REP*CHIP_DIV cycles with tx_valid=1 throughout.
  - tx_sof is high in the frame's first cycle only.
  - tx_eof is high in the frame's final cycle only.
  - When DATA_W*REP*CHIP_DIV=1, tx_sof and tx_eof are both high in the same cycle.
- SEND exit: after the final cycle, go to GAP if GAP>0, else IDLE. tx_valid=0 and tx_bit=0 from that edge.
- GAP: hold for exactly GAP cycles with in_ready=0, then go to IDLE with in_ready=1.
- Back-to-back: minimum spacing between tx_sof pulses = DATA_W*REP*CHIP_DIV + GAP + 1 cycles.
- Handshake: in_valid/in_data are ignored whenever in_ready=0. No queuing and no error flag.
- The latched word is immune to in_data changes after acceptance.
- Reset mid-frame: output stops immediately, the frame is truncated, no tx_eof is produced, and the word is discarded.
- Counter widths: sized by $clog2 of DATA_W, REP, CHIP_DIV and GAP (minimum 1 bit).
  - Counters never wrap mid-frame.
  - All counters clear on frame completion.

Test Plan:
- Basic frame (DATA_W=8, REP=3, CHIP_DIV=1, GAP=2): reset, then in_data=0xA5 accepted at edge 0.
  - Cycles 1..24: tx_bit = 111 000 111 000 000 111 000 111, tx_valid=1.
  - tx_sof high in cycle 1 only; tx_eof high in cycle 24 only.
  - tx_valid=0 in cycles 25-26; in_ready=1 from cycle 27.
- Loopback: drive 256 random words and feed each chip triplet into the majority voter. Recovered bits must equal the sent words LSB first.
  - Then flip one random chip per triplet; recovered words must still match.
- Handshake: hold in_valid=1 with in_data changing every cycle during SEND and GAP.
  - Exactly one frame per in_ready window.
  - Transmitted data equals the in_data value at the accepting edge.
  - tx_sof spacing is 27 cycles.
- Divider: CHIP_DIV=2, in_data=0x01.
  - Frame is 48 cycles: tx_bit=1 for 6 cycles, then 0 for 42.
  - tx_eof in cycle 48.
- Reset mid-frame: assert rst_n=0 in cycle 10 of a frame.
  - All outputs are 0 at once, with no tx_eof.
  - After release, in_ready=1 on the first edge, and a new word 0x3C transmits correctly.
- GAP=0, DATA_W=1, REP=3: in_data=1.
  - tx_bit=1 for 3 cycles; tx_sof in cycle 1, tx_eof in cycle 3.
  - in_ready=1 in cycle 4; next tx_sof no earlier than cycle 5.
